// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master arbiter and one-access sequencer in front of the mmio slave.
// Define MMIO_ARB_LOCK_EN to add m0_lock_i/m1_lock_i back-to-back bus locking.
module mmio_arbiter #(
    parameter int AW          = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [3:0]    m0_wmask_i,
    input  logic [31:0]   m0_wdata_i,
    input  logic          m1_req_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [3:0]    m1_wmask_i,
    input  logic [31:0]   m1_wdata_i,
`ifdef MMIO_ARB_LOCK_EN
    input  logic          m0_lock_i,
    input  logic          m1_lock_i,
`endif
    output logic          m0_gnt_o,
    output logic          m1_gnt_o,
    output logic          m0_rvalid_o,
    output logic          m1_rvalid_o,
    output logic [31:0]   m0_rdata_o,
    output logic [31:0]   m1_rdata_o,
    output logic [AW-1:0] s_addr_o,
    output logic [3:0]    s_wmask_o,
    output logic [31:0]   s_wdata_o,
    input  logic [31:0]   s_rdata_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [3:0]    s_wmask_q, s_wmask_d;
    logic [31:0]   s_wdata_q, s_wdata_d;
    logic [31:0]   m0_rdata_q, m0_rdata_d;
    logic [31:0]   m1_rdata_q, m1_rdata_d;
    logic          both, rr_pick, hold, pick, win_en, cap;
`ifdef MMIO_ARB_LOCK_EN
    logic          lock_q, lock_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == ISSUE) ? RESP : win_en ? ISSUE : IDLE;
    end

    always_comb begin
        m0_gnt_o    = (state_q == ISSUE) && !last_q;
        m1_gnt_o    = (state_q == ISSUE) &&  last_q;
        m0_rvalid_o = (state_q == RESP)  && !last_q;
        m1_rvalid_o = (state_q == RESP)  &&  last_q;
        m0_rdata_o  = m0_rdata_q;
        m1_rdata_o  = m1_rdata_q;
        s_addr_o    = s_addr_q;
        s_wmask_o   = s_wmask_q;
        s_wdata_o   = s_wdata_q;
    end

    // last_q doubles as the owner of the access in flight and the round-robin pointer
    always_comb begin
        both    = m0_req_i & m1_req_i;
        rr_pick = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
`ifdef MMIO_ARB_LOCK_EN
        hold    = (state_q == RESP) && lock_q && (last_q ? m1_req_i : m0_req_i);
`else
        hold    = 1'b0;
`endif
        pick    = hold ? last_q : both ? rr_pick : m1_req_i;
        win_en  = (state_q != ISSUE) && (m0_req_i | m1_req_i);
        cap     = (state_q == ISSUE);
    end

    // wmask is only non-zero for the single ISSUE cycle that follows a win
    always_comb begin
        last_d     = win_en ? pick : last_q;
        s_addr_d   = win_en ? (pick ? m1_addr_i : m0_addr_i) : s_addr_q;
        s_wdata_d  = win_en ? (pick ? m1_wdata_i : m0_wdata_i) : s_wdata_q;
        s_wmask_d  = win_en ? (pick ? m1_wmask_i : m0_wmask_i) : 4'b0000;
        m0_rdata_d = (cap && !last_q) ? s_rdata_i : m0_rdata_q;
        m1_rdata_d = (cap &&  last_q) ? s_rdata_i : m1_rdata_q;
`ifdef MMIO_ARB_LOCK_EN
        lock_d     = win_en ? (pick ? m1_lock_i : m0_lock_i) : lock_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            s_addr_q   <= '0;
            s_wmask_q  <= 4'b0000;
            s_wdata_q  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            last_q     <= last_d;
            s_addr_q   <= s_addr_d;
            s_wmask_q  <= s_wmask_d;
            s_wdata_q  <= s_wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

`ifdef MMIO_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`endif

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: random two-master traffic against a transaction-level model with a
// scoreboard, plus directed reads/writes, mid-access reset and a fixed-priority instance.
module tb_mmio_arbiter;
    localparam int AW = 32;
    localparam int RR = 1;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_lock = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;
    logic        f_en = 1'b0;
    logic        f0_gnt, f1_gnt, f0_rv, f1_rv;
    logic [31:0] f0_rd, f1_rd, f_addr, f_wdata;
    logic [3:0]  f_wmask;

    always #5 clk = ~clk;

    mmio_arbiter #(.AW(AW), .ROUND_ROBIN(RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wmask_i(m0_wmask), .m0_wdata_i(m0_wdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wmask_i(m1_wmask), .m1_wdata_i(m1_wdata),
`ifdef MMIO_ARB_LOCK_EN
        .m0_lock_i(m0_lock), .m1_lock_i(m1_lock),
`endif
        .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt), .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
        .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
        .s_addr_o(s_addr), .s_wmask_o(s_wmask), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata)
    );

    mmio_arbiter #(.AW(AW), .ROUND_ROBIN(0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(f_en), .m0_addr_i(32'h0), .m0_wmask_i(4'h0), .m0_wdata_i(32'h0),
        .m1_req_i(f_en), .m1_addr_i(32'h4), .m1_wmask_i(4'h0), .m1_wdata_i(32'h0),
`ifdef MMIO_ARB_LOCK_EN
        .m0_lock_i(1'b0), .m1_lock_i(1'b0),
`endif
        .m0_gnt_o(f0_gnt), .m1_gnt_o(f1_gnt), .m0_rvalid_o(f0_rv), .m1_rvalid_o(f1_rv),
        .m0_rdata_o(f0_rd), .m1_rdata_o(f1_rd),
        .s_addr_o(f_addr), .s_wmask_o(f_wmask), .s_wdata_o(f_wdata), .s_rdata_i(32'h1234_5678)
    );

    // Slave: four mapped words below 0x10, everything above reads 0xCCCC_CCCC
    logic [31:0] smem [4] = '{32'h11, 32'h0A, 32'h33, 32'h44};
    logic [31:0] ref_mem [4] = '{32'h11, 32'h0A, 32'h33, 32'h44};
    assign s_rdata = (s_addr < 32'h10) ? smem[s_addr[3:2]] : 32'hCCCC_CCCC;
    always @(posedge clk)
        if (s_wmask != 4'h0 && s_addr < 32'h10)
            for (int b = 0; b < 4; b++)
                if (s_wmask[b]) smem[s_addr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];

    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit who; logic [31:0] addr; logic [3:0] wm; logic [31:0] wd; } gexp_t;
    typedef struct { int cyc; bit who; logic [31:0] data; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return (a < 32'h10) ? ref_mem[a[3:2]] : 32'hCCCC_CCCC;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd);
        if (a < 32'h10)
            for (int b = 0; b < 4; b++)
                if (wm[b]) ref_mem[a[3:2]][8*b +: 8] = wd[8*b +: 8];
    endfunction

    // Monitor: pops expectations whenever the DUT shows gnt or rvalid
    always @(posedge clk) begin
        gexp_t g;
        rexp_t r;
        #1;
        if (mon_en) begin
            chk("gnt_excl", {31'b0, m0_gnt & m1_gnt}, 32'h0);
            chk("rvalid_excl", {31'b0, m0_rvalid & m1_rvalid}, 32'h0);
            if (m0_gnt | m1_gnt) begin
                if (gq.size() == 0) chk("gnt_spurious", 32'h1, 32'h0);
                else begin
                    g = gq.pop_front();
                    chk("gnt_cyc", cyc, g.cyc);
                    chk("gnt_who", {31'b0, m1_gnt}, {31'b0, g.who});
                    chk("s_addr", s_addr, g.addr);
                    chk("s_wmask", {28'b0, s_wmask}, {28'b0, g.wm});
                    chk("s_wdata", s_wdata, g.wd);
                end
            end else begin
                chk("wmask_idle", {28'b0, s_wmask}, 32'h0);
                if (gq.size() != 0 && gq[0].cyc <= cyc) begin
                    chk("gnt_missing", 32'h0, 32'h1);
                    void'(gq.pop_front());
                end
            end
            if (m0_rvalid | m1_rvalid) begin
                if (rq.size() == 0) chk("rvalid_spurious", 32'h1, 32'h0);
                else begin
                    r = rq.pop_front();
                    chk("rv_cyc", cyc, r.cyc);
                    chk("rv_who", {31'b0, m1_rvalid}, {31'b0, r.who});
                    chk("rdata", r.who ? m1_rdata : m0_rdata, r.data);
                    chk("rdata_loser_hold", r.who ? m0_rdata : m1_rdata, last_rd[!r.who]);
                    last_rd[r.who] = r.data;
                end
            end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
                chk("rvalid_missing", 32'h0, 32'h1);
                void'(rq.pop_front());
            end
        end
    end

    task automatic do_acc(input bit who, input logic [31:0] a, input logic [3:0] wm,
                          input logic [31:0] wd, input logic [31:0] exp);
        @(posedge clk); #2;
        m0_req = !who; m1_req = who;
        m0_addr = a; m1_addr = a; m0_wmask = wm; m1_wmask = wm; m0_wdata = wd; m1_wdata = wd;
        @(posedge clk); #1;
        chk("acc_gnt", {30'b0, m1_gnt, m0_gnt}, who ? 32'h2 : 32'h1);
        chk("acc_wmask", {28'b0, s_wmask}, {28'b0, wm});
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;
        chk("acc_rvalid", {30'b0, m1_rvalid, m0_rvalid}, who ? 32'h2 : 32'h1);
        chk("acc_rdata", who ? m1_rdata : m0_rdata, exp);
        chk("acc_wmask_off", {28'b0, s_wmask}, 32'h0);
        @(posedge clk); #1;
        chk("acc_idle", {28'b0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}, 32'h0);
        model_write(a, wm, wd);
    endtask

    initial begin
        bit          p [2] = '{1'b0, 1'b0};
        bit          lk [2] = '{1'b0, 1'b0};
        logic [31:0] pa [2], pd [2];
        logic [3:0]  pm [2];
        bit          last_w = 1'b1, lock_held = 1'b0, w;
        int          next_arb = 0, lw_edge = -10, e, n0, n1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_ctl", {28'b0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}, 32'h0);
        chk("reset_wmask", {28'b0, s_wmask}, 32'h0);
        chk("reset_addr", s_addr, 32'h0);
        chk("reset_wdata", s_wdata, 32'h0);
        chk("reset_rdata", m0_rdata | m1_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            e = cyc + 1;
            for (int m = 0; m < 2; m++)
                if (!p[m] && (i == 0 || $urandom_range(0, 99) < 40)) begin
                    p[m]  = 1'b1;
                    pa[m] = 32'($urandom_range(0, 5)) * 4;
                    pm[m] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                    pd[m] = $urandom;
                    lk[m] = ($urandom_range(0, 2) == 0);
                end
            m0_req = p[0]; m0_addr = pa[0]; m0_wmask = pm[0]; m0_wdata = pd[0];
            m1_req = p[1]; m1_addr = pa[1]; m1_wmask = pm[1]; m1_wdata = pd[1];
`ifdef MMIO_ARB_LOCK_EN
            m0_lock = p[0] && lk[0]; m1_lock = p[1] && lk[1];
`endif
            if (e >= next_arb && (p[0] || p[1])) begin
                w = (p[0] && p[1]) ? ((RR != 0) ? !last_w : 1'b0) : p[1];
`ifdef MMIO_ARB_LOCK_EN
                if (e == lw_edge + 2 && lock_held && p[last_w]) w = last_w;
`endif
                gq.push_back('{e, w, pa[w], pm[w], pd[w]});
                rq.push_back('{e + 1, w, model_read(pa[w])});
                model_write(pa[w], pm[w], pd[w]);
                last_w = w; lock_held = lk[w]; lw_edge = e; next_arb = e + 2;
                p[w] = 1'b0;
            end
        end
        @(posedge clk); #2;
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("drain_gnt_q", gq.size(), 32'h0);
        chk("drain_rv_q", rq.size(), 32'h0);
        mon_en = 1'b0;
        for (int j = 0; j < 4; j++) chk("slave_vs_model", smem[j], ref_mem[j]);

        do_acc(1'b0, 32'h4, 4'h0, 32'h0, model_read(32'h4));
        do_acc(1'b1, 32'h4, 4'hF, 32'h5, model_read(32'h4));
        chk("slave_odr", smem[1], 32'h5);
        do_acc(1'b0, 32'h4, 4'h0, 32'h0, 32'h5);
        do_acc(1'b0, 32'h10, 4'h0, 32'h0, 32'hCCCC_CCCC);

        @(posedge clk); #2;
        m0_req = 1'b1; m0_addr = 32'h4; m0_wmask = 4'h0;
        @(posedge clk); #1;
        chk("rst_mid_gnt", {31'b0, m0_gnt}, 32'h1);
        m0_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {28'b0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}, 32'h0);
        chk("rst_mid_wmask", {28'b0, s_wmask}, 32'h0);
        chk("rst_mid_addr", s_addr, 32'h0);
        chk("rst_mid_rdata", m0_rdata | m1_rdata, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_mid_no_rv", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        do_acc(1'b0, 32'h4, 4'h0, 32'h0, 32'h5);

        @(posedge clk); #2;
        f_en = 1'b1;
        n0 = 0; n1 = 0;
        repeat (20) begin
            @(posedge clk); #1;
            n0 += int'(f0_gnt); n1 += int'(f1_gnt);
        end
        f_en = 1'b0;
        chk("fixed_m0_gnts", n0, 32'd10);
        chk("fixed_m1_gnts", n1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
